// File: rtl/spi_share_arbiter.sv
// ============================================================================
// Module : spi_share_arbiter
// Brief  : Round-robin sharing of one byte-wide SPI host engine between
//          NumReq requesters, with CS setup/hold/idle sequencing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_share_arbiter #(
  parameter int NumReq        = 4,
  parameter int CsSetupCycles = 2,
  parameter int CsHoldCycles  = 2,
  parameter int CsIdleCycles  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  input  logic [NumReq-1:0]   req_last_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic [NumReq-1:0]   rsp_valid_o,
  output logic [7:0]          rsp_data_o,
  output logic                host_valid_o,
  output logic [7:0]          host_data_o,
  input  logic                host_ready_i,
  input  logic                host_rsp_valid_i,
  input  logic [7:0]          host_rsp_data_i,
  output logic [NumReq-1:0]   cs_no,
  output logic [NumReq-1:0]   grant_o,
  output logic                busy_o
);

  localparam int IdxW = $clog2(NumReq);

  if (NumReq < 2 || NumReq > 8 ||
      CsSetupCycles < 1 || CsSetupCycles > 15 ||
      CsHoldCycles  < 1 || CsHoldCycles  > 15 ||
      CsIdleCycles  < 1 || CsIdleCycles  > 15) begin : g_bad_param
    $error("spi_share_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_XFER     = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_HOLD     = 3'd4,
    S_GAP      = 3'd5
  } state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [NumReq-1:0] r_grant, w_grant_d;
  logic [IdxW-1:0]   r_gidx, w_gidx_d;
  logic [IdxW-1:0]   r_rr_ptr, w_rr_d;
  logic              r_last, w_last_d;

  logic              w_pick_vld;
  logic [IdxW-1:0]   w_pick_idx;
  logic [IdxW-1:0]   w_scan;
  logic              w_hs;

  // First requesting index at or above rr_ptr, wrapping at NumReq.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_scan     = r_rr_ptr;
    for (int k = 0; k < NumReq; k++) begin
      if (!w_pick_vld && req_valid_i[w_scan]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_scan;
      end
      w_scan = (w_scan == IdxW'(NumReq - 1)) ? '0 : w_scan + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
      r_last   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_grant  <= w_grant_d;
      r_gidx   <= w_gidx_d;
      r_rr_ptr <= w_rr_d;
      r_last   <= w_last_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_grant_d    = r_grant;
    w_gidx_d     = r_gidx;
    w_rr_d       = r_rr_ptr;
    w_last_d     = r_last;
    w_hs         = 1'b0;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    rsp_data_o   = 8'h00;
    host_valid_o = 1'b0;
    host_data_o  = 8'h00;

    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_grant_d = NumReq'(1) << w_pick_idx;
          w_gidx_d  = w_pick_idx;
          w_cnt_d   = 4'(CsSetupCycles);
          w_state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        w_cnt_d = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_d = S_XFER;
      end
      S_XFER: begin
        host_valid_o = req_valid_i[r_gidx];
        host_data_o  = req_data_i[{r_gidx, 3'b000} +: 8];
        req_ready_o  = r_grant & {NumReq{host_ready_i}};
        w_hs         = req_valid_i[r_gidx] & host_ready_i;
        if (w_hs) begin
          w_last_d  = req_last_i[r_gidx];
          w_state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (host_rsp_valid_i) begin
          rsp_valid_o = r_grant;
          rsp_data_o  = host_rsp_data_i;
          if (r_last) begin
            w_cnt_d   = 4'(CsHoldCycles);
            w_state_d = S_HOLD;
          end else begin
            w_state_d = S_XFER;
          end
        end
      end
      S_HOLD: begin
        w_cnt_d = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_grant_d = '0;
          w_rr_d    = (r_gidx == IdxW'(NumReq - 1)) ? '0 : r_gidx + 1'b1;
          w_cnt_d   = 4'(CsIdleCycles);
          w_state_d = S_GAP;
        end
      end
      S_GAP: begin
        w_cnt_d = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  // CS is the registered grant inverted, so the two can never disagree.
  assign cs_no   = ~r_grant;
  assign grant_o = r_grant;
  assign busy_o  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_share_arbiter.sv
// ============================================================================
// Module : tb_spi_share_arbiter
// Brief  : Directed, scoreboard-checked bench for spi_share_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_share_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic        host_valid_o;
  logic [7:0]  host_data_o;
  logic        host_ready_i;
  logic        host_rsp_valid_i;
  logic [7:0]  host_rsp_data_i;
  logic [3:0]  cs_no;
  logic [3:0]  grant_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [11:0] sb[$];

  spi_share_arbiter dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_data_i       (req_data_i),
    .req_last_i       (req_last_i),
    .req_ready_o      (req_ready_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_data_o       (rsp_data_o),
    .host_valid_o     (host_valid_o),
    .host_data_o      (host_data_o),
    .host_ready_i     (host_ready_i),
    .host_rsp_valid_i (host_rsp_valid_i),
    .host_rsp_data_i  (host_rsp_data_i),
    .cs_no            (cs_no),
    .grant_o          (grant_o),
    .busy_o           (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: pops the scoreboard on every response pulse and watches CS.
  initial begin
    int hi;
    int armed;
    logic [11:0] e;
    hi = 0;
    armed = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        hi = 0;
        armed = 0;
      end else begin
        chk("grant_vs_cs", {28'd0, grant_o}, {28'd0, ~cs_no});
        chk("cs_onehot", 32'($onehot0(~cs_no)), 32'd1);
        if (rsp_valid_o != 4'd0) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", {20'd0, rsp_valid_o, rsp_data_o}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp", {20'd0, rsp_valid_o, rsp_data_o}, {20'd0, e});
          end
        end else begin
          chk("rsp_data_idle", {24'd0, rsp_data_o}, 32'd0);
        end
        if (&cs_no) begin
          hi++;
        end else begin
          if (armed != 0 && hi != 0) begin
            total++;
            if (hi < 5) begin
              bad++;
              $display("FAIL cs_gap got=%0d exp>=5", hi);
            end
          end
          armed = 1;
          hi = 0;
        end
      end
    end
  end

  // Waits for the arbiter to offer a byte and checks who owns the bus.
  task automatic wait_offer(input int r, input logic [7:0] tx);
    int n;
    logic [3:0] oh;
    n = 0;
    oh = 4'(1 << r);
    @(negedge clk_i);
    while (!host_valid_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    if (!host_valid_o) begin
      chk("offer_timeout", 32'd0, 32'd1);
    end else begin
      chk("offer_grant", {28'd0, grant_o}, {28'd0, oh});
      chk("offer_cs", {28'd0, cs_no}, {28'd0, ~oh});
      chk("offer_data", {24'd0, host_data_o}, {24'd0, tx});
      chk("offer_ready", {28'd0, req_ready_o}, {28'd0, host_ready_i ? oh : 4'd0});
    end
  endtask

  // Completes a handshake already taken: next request inputs, then response.
  task automatic finish_xfer(input int r, input logic [7:0] rx,
                             input logic [3:0] nv, input logic [3:0] nl,
                             input logic [31:0] nd);
    logic [3:0] oh;
    oh = 4'(1 << r);
    next_cycle();
    req_valid_i = nv;
    req_last_i  = nl;
    req_data_i  = nd;
    next_cycle();
    host_rsp_valid_i = 1'b1;
    host_rsp_data_i  = rx;
    sb.push_back({oh, rx});
    next_cycle();
    host_rsp_valid_i = 1'b0;
    host_rsp_data_i  = 8'h00;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (3) next_cycle();
    rst_ni = 1'b1;
    next_cycle();
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    req_last_i = '0;
    host_ready_i = 1'b0;
    host_rsp_valid_i = 1'b0;
    host_rsp_data_i = 8'h00;
    do_reset();

    @(negedge clk_i);
    chk("rst_cs", {28'd0, cs_no}, 32'hF);
    chk("rst_grant", {28'd0, grant_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_hv", {31'd0, host_valid_o}, 32'd0);
    chk("rst_ready", {28'd0, req_ready_o}, 32'd0);
    next_cycle();

    // Single byte from requester 2, with spurious responses in IDLE/SETUP/GAP.
    for (int c = -1; c <= 13; c++) begin
      case (c)
        -1: begin host_rsp_valid_i = 1'b1; host_rsp_data_i = 8'h55; end
        0: begin
          host_rsp_valid_i = 1'b0;
          req_valid_i = 4'b0100;
          req_last_i = 4'b0100;
          req_data_i = 32'h00A5_0000;
          host_ready_i = 1'b1;
        end
        1: begin host_rsp_valid_i = 1'b1; host_rsp_data_i = 8'h66; end
        2: begin host_rsp_valid_i = 1'b0; host_rsp_data_i = 8'h00; end
        4: req_valid_i = 4'b0000;
        6: begin
          host_rsp_valid_i = 1'b1;
          host_rsp_data_i = 8'h3C;
          sb.push_back({4'b0100, 8'h3C});
        end
        7: begin host_rsp_valid_i = 1'b0; host_rsp_data_i = 8'h00; end
        10: begin host_rsp_valid_i = 1'b1; host_rsp_data_i = 8'h99; end
        11: begin host_rsp_valid_i = 1'b0; host_rsp_data_i = 8'h00; end
        default: ;
      endcase
      @(negedge clk_i);
      case (c)
        0: chk("t1_c0_cs", {28'd0, cs_no}, 32'hF);
        1: begin
          chk("t1_c1_cs", {28'd0, cs_no}, 32'hB);
          chk("t1_c1_grant", {28'd0, grant_o}, 32'h4);
          chk("t1_c1_busy", {31'd0, busy_o}, 32'd1);
        end
        2: begin
          chk("t1_c2_hv", {31'd0, host_valid_o}, 32'd0);
          chk("t1_c2_hd", {24'd0, host_data_o}, 32'd0);
        end
        3: begin
          chk("t1_c3_hv", {31'd0, host_valid_o}, 32'd1);
          chk("t1_c3_hd", {24'd0, host_data_o}, 32'hA5);
          chk("t1_c3_ready", {28'd0, req_ready_o}, 32'h4);
        end
        4: begin
          chk("t1_c4_ready", {28'd0, req_ready_o}, 32'd0);
          chk("t1_c4_hv", {31'd0, host_valid_o}, 32'd0);
        end
        8: chk("t1_c8_cs", {28'd0, cs_no}, 32'hB);
        9: begin
          chk("t1_c9_cs", {28'd0, cs_no}, 32'hF);
          chk("t1_c9_grant", {28'd0, grant_o}, 32'd0);
        end
        12: chk("t1_c12_busy", {31'd0, busy_o}, 32'd1);
        13: chk("t1_c13_busy", {31'd0, busy_o}, 32'd0);
        default: ;
      endcase
      next_cycle();
    end

    // Round-robin with all four requesting continuously.
    do_reset();
    req_valid_i = 4'hF;
    req_last_i = 4'hF;
    req_data_i = 32'h1312_1110;
    host_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_offer(k % 4, 8'(8'h10 + (k % 4)));
      finish_xfer(k % 4, 8'(8'hC0 + k), 4'hF, 4'hF, 32'h1312_1110);
    end

    // Burst of three bytes from requester 1 while requester 0 waits.
    req_valid_i = 4'b0011;
    req_last_i = 4'b0001;
    req_data_i = 32'h0000_01E0;
    wait_offer(1, 8'h01);
    finish_xfer(1, 8'hA1, 4'b0011, 4'b0001, 32'h0000_02E0);
    wait_offer(1, 8'h02);
    finish_xfer(1, 8'hA2, 4'b0011, 4'b0011, 32'h0000_03E0);
    wait_offer(1, 8'h03);
    finish_xfer(1, 8'hA3, 4'b0001, 4'b0001, 32'h0000_00E0);

    // Requester 0 offered while the engine stalls, then drops valid.
    host_ready_i = 1'b0;
    wait_offer(0, 8'hE0);
    for (int s = 0; s < 10; s++) begin
      next_cycle();
      @(negedge clk_i);
      chk("stall_hv", {31'd0, host_valid_o}, 32'd1);
      chk("stall_hd", {24'd0, host_data_o}, 32'hE0);
      chk("stall_ready", {28'd0, req_ready_o}, 32'd0);
    end
    next_cycle();
    req_valid_i = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk_i);
      chk("drop_cs", {28'd0, cs_no}, 32'hE);
      chk("drop_hv", {31'd0, host_valid_o}, 32'd0);
      next_cycle();
    end
    req_valid_i = 4'b0001;
    host_ready_i = 1'b1;
    @(negedge clk_i);
    chk("resume_hv", {31'd0, host_valid_o}, 32'd1);
    chk("resume_ready", {28'd0, req_ready_o}, 32'h1);
    finish_xfer(0, 8'h5A, 4'b0000, 4'b0000, 32'h0000_0000);

    // Reset while waiting for a response.
    req_valid_i = 4'b0100;
    req_last_i = 4'b0100;
    req_data_i = 32'h0077_0000;
    wait_offer(2, 8'h77);
    next_cycle();
    req_valid_i = 4'b0000;
    rst_ni = 1'b0;
    #1;
    chk("arst_cs", {28'd0, cs_no}, 32'hF);
    chk("arst_grant", {28'd0, grant_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
    req_valid_i = 4'b1000;
    req_last_i = 4'b1000;
    req_data_i = 32'h9900_0000;
    wait_offer(3, 8'h99);
    finish_xfer(3, 8'h42, 4'b0000, 4'b0000, 32'h0000_0000);

    repeat (15) next_cycle();
    @(negedge clk_i);
    chk("end_busy", {31'd0, busy_o}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/spi_share_arbiter.md
# spi_share_arbiter

Shares a single byte-wide SPI host shift engine between `NumReq` requesters, one chip select per requester. It arbitrates between the requesters round-robin and sequences CS setup, byte transfers, CS hold and inter-transaction idle gaps. It sits between the system-side SPI clients and the SPI host engine that drives `sck`/`copi`/`cipo` toward the flash, LCD and other SPI devices.

## Interface
Parameters:
- `NumReq`, 4: number of requesters and chip selects; range 2..8.
- `CsSetupCycles`, 2: cycles CS is low before the first byte is offered; range 1..15.
- `CsHoldCycles`, 2: cycles CS stays low after the last response; range 1..15.
- `CsIdleCycles`, 4: cycles CS is high before the next grant; range 1..15.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NumReq  requester has a byte to send.
- `req_data_i`  in  NumReq*8  per-requester TX byte; requester i uses bits [8i+7:8i].
- `req_last_i`  in  NumReq  the offered byte ends the transaction.
- `req_ready_o`  out  NumReq  byte accepted this cycle.
- `rsp_valid_o`  out  NumReq  one-cycle pulse: received byte for requester i.
- `rsp_data_o`  out  8  received byte; shared by all requesters.
- `host_valid_o`  out  1  byte offered to the shift engine.
- `host_data_o`  out  8  byte to shift out.
- `host_ready_i`  in  1  shift engine accepts the byte.
- `host_rsp_valid_i`  in  1  shift engine finished the byte.
- `host_rsp_data_i`  in  8  byte shifted in.
- `cs_no`  out  NumReq  active-low chip selects.
- `grant_o`  out  NumReq  one-hot current owner; zero when there is no owner.
- `busy_o`  out  1  state is not IDLE.

## Operation
- States: IDLE, SETUP, XFER, WAIT_RSP, HOLD, GAP. The state, grant, CS, counter, last flag and `rr_ptr` are registered.
- **IDLE.** If any `req_valid_i` is set, pick the first set bit searching upward from `rr_ptr`, wrapping at NumReq. Load the grant, drive that CS low, load the counter with CsSetupCycles, go to SETUP.
- **SETUP.** Decrement the counter each cycle. When it reaches 1, go to XFER.
- **XFER.**
  - `host_valid_o` = `req_valid_i[g]`.
  - `host_data_o` = the data slice of `g`.
  - `req_ready_o[g]` = `host_ready_i`.
  - On the handshake (valid & ready), latch `req_last_i[g]` and go to WAIT_RSP.
  - If the granted requester drops valid, wait indefinitely with CS low. There is no timeout.
- **WAIT_RSP.** On `host_rsp_valid_i`, pulse `rsp_valid_o[g]` combinationally in the same cycle, with `rsp_data_o` = `host_rsp_data_i`. Then go to HOLD (counter = CsHoldCycles) if the latched last flag is set, otherwise back to XFER.
- **HOLD.** Count down with CS low. On expiry, drive CS high, clear the grant, set `rr_ptr` = (g+1) mod NumReq, load the counter with CsIdleCycles, go to GAP.
- **GAP.** Count down with all CS high. On expiry, go to IDLE.
- Ignored inputs:
  - `host_rsp_valid_i` outside WAIT_RSP.
  - `host_ready_i` outside XFER.
  - Requests from non-granted requesters. They are held off with `req_ready_o`=0.
- Invariants:
  - At most one `cs_no` bit is low, and only while the state is in SETUP..HOLD.
  - `grant_o` equals the inverse of `cs_no`.
- `host_data_o` is 0 outside XFER. `rsp_data_o` is 0 outside the response pulse.
- Counters are 4 bits. Parameter values outside the stated ranges are an elaboration error.

## Timing
- Reset values (asynchronous, immediate, including mid-transaction):
  - `cs_no` all ones; `grant_o` 0; `busy_o` 0.
  - `req_ready_o`, `rsp_valid_o`, `host_valid_o` 0; `host_data_o`, `rsp_data_o` 0.
  - State IDLE; `rr_ptr` 0.
- A request sampled in IDLE at cycle 0 gives CS low and `grant_o`/`busy_o` set from cycle 1.
- SETUP occupies cycles 1..CsSetupCycles. The earliest handshake is at cycle CsSetupCycles+1.
- Each further byte enters XFER on the cycle after its response.
- HOLD spans CsHoldCycles cycles after the last response. CS goes high on the cycle after HOLD expires.
- GAP gives CsIdleCycles cycles with CS high. The earliest next grant is sampled in the following IDLE cycle.
- Minimum CS-high time between back-to-back transactions is CsIdleCycles+1 cycles.

## Test plan
- **Single byte.** With defaults, requester 2 asserts valid+last with data 0xA5 at cycle 0.
  - `cs_no`=4'b1011 from cycle 1.
  - `host_valid_o` at cycle 3, handshake at cycle 3.
  - `host_rsp_valid_i`=1 with data 0x3C at cycle 6 gives `rsp_valid_o`=4'b0100, `rsp_data_o`=0x3C at cycle 6.
  - CS high at cycle 9; `busy_o` low at cycle 13.
- **Round-robin.** All four requesters hold 1-byte requests continuously. Grants occur in order 0,1,2,3,0, and no CS-high gap is shorter than 5 cycles.
- **Multi-byte burst.** Requester 1 sends 0x01, 0x02, 0x03, last on 0x03, while requester 0 is also requesting.
  - CS1 stays low across all three bytes, with 3 responses routed to requester 1 only.
  - Requester 0 gets no grant until GAP ends.
- **Stalls.**
  - `host_ready_i` held low for 10 cycles: `host_valid_o` and `host_data_o` stay stable and `req_ready_o` stays 0.
  - Requester deasserts valid mid-burst: CS stays low and the state stays XFER.
- **Spurious inputs.** `host_rsp_valid_i` pulsed in IDLE, SETUP and GAP produces no `rsp_valid_o`.
- **Reset mid-operation.** `rst_ni` asserted during WAIT_RSP drives all `cs_no` high in the same cycle. After release, a request from requester 3 is granted starting from `rr_ptr`=0.
